// File: rtl/vga_scan_if.sv
// Signal bundle between vga_scan_ctrl, the graphics source and the VGA connector.
// The i_test_mode member exists only when TEST_PATTERN_EN is defined.
interface vga_scan_if;
    logic [3:0] i_r;
    logic [3:0] i_g;
    logic [3:0] i_b;
`ifdef TEST_PATTERN_EN
    logic       i_test_mode;
`endif
    logic [9:0] o_x_read;
    logic [9:0] o_y_read;
    logic       o_hs;
    logic       o_vs;
    logic [3:0] o_r;
    logic [3:0] o_g;
    logic [3:0] o_b;
    logic       o_vblank_start;

`ifdef TEST_PATTERN_EN
    modport master (
        input  i_r, i_g, i_b, i_test_mode,
        output o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_vblank_start
    );
    modport slave (
        output i_r, i_g, i_b, i_test_mode,
        input  o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_vblank_start
    );
`else
    modport master (
        input  i_r, i_g, i_b,
        output o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_vblank_start
    );
    modport slave (
        output i_r, i_g, i_b,
        input  o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_vblank_start
    );
`endif
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing around the graphics block: scan coordinates out, delayed sync/blank/RGB in.
// Optional macro TEST_PATTERN_EN adds an eight-bar colour test pattern selected by i_test_mode.
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int PIPE_LAT = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_scan_if.master bus
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                tick;
    logic [9:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                act_nxt, hs_n_nxt, vs_n_nxt;
    logic [PIPE_LAT-1:0] pipe_act_q, pipe_act_d;
    logic [PIPE_LAT-1:0] pipe_hs_q, pipe_hs_d;
    logic [PIPE_LAT-1:0] pipe_vs_q, pipe_vs_d;
    logic                hs_q, hs_d, vs_q, vs_d;
    logic                vblank_q, vblank_d;
    logic [11:0]         rgb_q, rgb_d, rgb_src;

`ifdef TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    logic [PIPE_LAT-1:0][9:0] pipe_hx_q, pipe_hx_d;

    function automatic logic [11:0] bar_color(input logic [9:0] hx);
        logic [9:0] idx;
        idx = hx / BAR_W;
        case (idx)
            10'd0:   bar_color = 12'hFFF;
            10'd1:   bar_color = 12'hFF0;
            10'd2:   bar_color = 12'h0FF;
            10'd3:   bar_color = 12'h0F0;
            10'd4:   bar_color = 12'hF0F;
            10'd5:   bar_color = 12'hF00;
            10'd6:   bar_color = 12'h00F;
            default: bar_color = 12'h000;
        endcase
    endfunction
`endif

    assign tick = (div_cnt_q == DIV_LAST);

    // Pixel divider and raster counters; v advances only when h wraps.
    always_comb begin
        div_cnt_d = tick ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Timing terms belong to the coordinate being issued on this tick.
    always_comb begin
        act_nxt  = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        hs_n_nxt = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
        vs_n_nxt = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
    end

    // Colour source: graphics input, or the bar pattern when test mode is on.
    always_comb begin
        rgb_src = {bus.i_r, bus.i_g, bus.i_b};
`ifdef TEST_PATTERN_EN
        if (bus.i_test_mode) begin
            rgb_src = bar_color(pipe_hx_q[PIPE_LAT-1]);
        end else begin
            rgb_src = {bus.i_r, bus.i_g, bus.i_b};
        end
`endif
    end

    // Alignment pipeline and output registers; the oldest stage matches the RGB now arriving.
    always_comb begin
        pipe_act_d = pipe_act_q;
        pipe_hs_d  = pipe_hs_q;
        pipe_vs_d  = pipe_vs_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        rgb_d      = rgb_q;
        vblank_d   = 1'b0;
`ifdef TEST_PATTERN_EN
        pipe_hx_d  = pipe_hx_q;
`endif
        if (tick) begin
            pipe_act_d = PIPE_LAT'({pipe_act_q, act_nxt});
            pipe_hs_d  = PIPE_LAT'({pipe_hs_q, hs_n_nxt});
            pipe_vs_d  = PIPE_LAT'({pipe_vs_q, vs_n_nxt});
`ifdef TEST_PATTERN_EN
            pipe_hx_d  = (PIPE_LAT * 10)'({pipe_hx_q, h_cnt_d});
`endif
            hs_d       = pipe_hs_q[PIPE_LAT-1];
            vs_d       = pipe_vs_q[PIPE_LAT-1];
            rgb_d      = pipe_act_q[PIPE_LAT-1] ? rgb_src : 12'h000;
            vblank_d   = (h_cnt_d == 10'd0) && (v_cnt_d == V_ACT);
        end else begin
            vblank_d   = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= {DIV_W{1'b0}};
            h_cnt_q    <= 10'd0;
            v_cnt_q    <= 10'd0;
            pipe_act_q <= {PIPE_LAT{1'b0}};
            pipe_hs_q  <= {PIPE_LAT{1'b1}};
            pipe_vs_q  <= {PIPE_LAT{1'b1}};
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            rgb_q      <= 12'h000;
            vblank_q   <= 1'b0;
`ifdef TEST_PATTERN_EN
            pipe_hx_q  <= {(PIPE_LAT * 10){1'b0}};
`endif
        end else begin
            div_cnt_q  <= div_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            pipe_act_q <= pipe_act_d;
            pipe_hs_q  <= pipe_hs_d;
            pipe_vs_q  <= pipe_vs_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            rgb_q      <= rgb_d;
            vblank_q   <= vblank_d;
`ifdef TEST_PATTERN_EN
            pipe_hx_q  <= pipe_hx_d;
`endif
        end
    end

    assign bus.o_x_read       = h_cnt_q;
    assign bus.o_y_read       = v_cnt_q;
    assign bus.o_hs           = hs_q;
    assign bus.o_vs           = vs_q;
    assign bus.o_r            = rgb_q[11:8];
    assign bus.o_g            = rgb_q[7:4];
    assign bus.o_b            = rgb_q[3:0];
    assign bus.o_vblank_start = vblank_q;
endmodule
